// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - DMType codes, drain states and lane-packing helpers for dmem_resp
package dmem_resp_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    localparam logic [0:0] DRAIN_IDLE  = 1'b0;
    localparam logic [0:0] DRAIN_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ACC_WORD = 2'd0,
        ACC_HALF = 2'd1,
        ACC_BYTE = 2'd2
    } acc_size_e;

    // Unknown DMType codes fall back to a word access.
    function automatic acc_size_e dm_size(input logic [2:0] dm);
        case (dm)
            DM_HALF, DM_HALF_U: dm_size = ACC_HALF;
            DM_BYTE, DM_BYTE_U: dm_size = ACC_BYTE;
            default:            dm_size = ACC_WORD;
        endcase
    endfunction

    function automatic logic dm_signed(input logic [2:0] dm);
        dm_signed = (dm == DM_HALF) || (dm == DM_BYTE);
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] dm, input logic [1:0] a);
        case (dm_size(dm))
            ACC_HALF: dm_misaligned = a[0];
            ACC_BYTE: dm_misaligned = 1'b0;
            default:  dm_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] dm_store_be(input logic [2:0] dm, input logic [1:0] a);
        case (dm_size(dm))
            ACC_HALF: dm_store_be = 4'b0011 << {a[1], 1'b0};
            ACC_BYTE: dm_store_be = 4'b0001 << a;
            default:  dm_store_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] dm_store_data(input logic [2:0] dm, input logic [31:0] w);
        case (dm_size(dm))
            ACC_HALF: dm_store_data = {2{w[15:0]}};
            ACC_BYTE: dm_store_data = {4{w[7:0]}};
            default:  dm_store_data = w;
        endcase
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - circular posted-write FIFO exposing every entry in age order (0 = oldest)
module dmem_wbuf #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [IDX_W-1:0]         push_idx,
    input  logic [3:0]               push_be,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [IDX_W-1:0]         ent_idx  [DEPTH],
    output logic [3:0]               ent_be   [DEPTH],
    output logic [31:0]              ent_data [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] slot_idx_q  [DEPTH];
    logic [3:0]       slot_be_q   [DEPTH];
    logic [31:0]      slot_data_q [DEPTH];

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot payloads need no reset: validity is derived from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_idx_q[tail_q]  <= push_idx;
            slot_be_q[tail_q]   <= push_be;
            slot_data_q[tail_q] <= push_data;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = CNT_W'(k) < count_q;
            ent_idx[k]   = slot_idx_q[head_q + PTR_W'(k)];
            ent_be[k]    = slot_be_q[head_q + PTR_W'(k)];
            ent_data[k]  = slot_data_q[head_q + PTR_W'(k)];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - MEM-stage data memory: lane packing, posted write buffer, slow array drain, merged loads
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int WB_DEPTH = 4,
    parameter int WR_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_w,
    input  logic [2:0]                  DMType,
    input  logic [31:0]                 Addr_in,
    input  logic [31:0]                 WData_in,
    output logic [31:0]                 RData_out,
    output logic                        misalign,
    input  logic [ADDR_W-1:0]           dbg_addr,
    output logic [31:0]                 dbg_data,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    output logic                        wb_full,
    output logic                        overflow
);

    localparam int CNT_W  = $clog2(WB_DEPTH) + 1;
    localparam int BEAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        a_lo;
    logic              addr_unused;

    assign idx         = Addr_in[ADDR_W+1:2];
    assign a_lo        = Addr_in[1:0];
    assign addr_unused = ^Addr_in[31:ADDR_W+2];

    logic [31:0] mem_q [2**ADDR_W];

    logic [0:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, store_ok;

    logic [WB_DEPTH-1:0] ent_valid;
    logic [ADDR_W-1:0]   ent_idx  [WB_DEPTH];
    logic [3:0]          ent_be   [WB_DEPTH];
    logic [31:0]         ent_data [WB_DEPTH];

    assign misalign = dm_misaligned(DMType, a_lo);
    assign store_ok = mem_w && !misalign;
    assign wb_full  = (wb_count == CNT_W'(WB_DEPTH));
    assign pop      = (state_q == DRAIN_WRITE) && (beat_q == BEAT_W'(WR_LAT - 1));
    assign push     = store_ok && (!wb_full || pop);

    dmem_wbuf #(
        .DEPTH (WB_DEPTH),
        .IDX_W (ADDR_W)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_idx  (idx),
        .push_be   (dm_store_be(DMType, a_lo)),
        .push_data (dm_store_data(DMType, WData_in)),
        .pop       (pop),
        .count     (wb_count),
        .ent_valid (ent_valid),
        .ent_idx   (ent_idx),
        .ent_be    (ent_be),
        .ent_data  (ent_data)
    );

    // Leaving IDLE on the push edge itself gives commit exactly WR_LAT edges after the push.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            DRAIN_IDLE: begin
                if (wb_count != '0 || push) begin
                    state_d = DRAIN_WRITE;
                    beat_d  = '0;
                end
            end
            DRAIN_WRITE: begin
                if (pop) begin
                    beat_d = '0;
                    if (wb_count == CNT_W'(1) && !push) state_d = DRAIN_IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
        overflow_d = overflow_q || (store_ok && wb_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DRAIN_IDLE;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    // A head entry whose commit edge coincides with reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset && pop) begin
            for (int b = 0; b < 4; b++) begin
                if (ent_be[0][b]) mem_q[ent_idx[0]][8*b +: 8] <= ent_data[0][8*b +: 8];
            end
        end
    end

    logic [31:0] merged;
    logic [15:0] lane_half;
    logic [7:0]  lane_byte;

    always_comb begin
        merged = mem_q[idx];
        for (int k = 0; k < WB_DEPTH; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (ent_valid[k] && ent_idx[k] == idx && ent_be[k][b])
                    merged[8*b +: 8] = ent_data[k][8*b +: 8];
            end
        end
        lane_half = a_lo[1] ? merged[31:16] : merged[15:0];
        lane_byte = merged[{a_lo, 3'b000} +: 8];
        case (dm_size(DMType))
            ACC_HALF: RData_out = dm_signed(DMType) ? {{16{lane_half[15]}}, lane_half}
                                                    : {16'h0000, lane_half};
            ACC_BYTE: RData_out = dm_signed(DMType) ? {{24{lane_byte[7]}}, lane_byte}
                                                    : {24'h000000, lane_byte};
            default:  RData_out = merged;
        endcase
        if (misalign) RData_out = '0;
    end

    assign dbg_data = mem_q[dbg_addr];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed self-checking bench for dmem_resp (WR_LAT=2 and WR_LAT=8 instances)
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_w;
    logic [2:0]  DMType;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  dbg_addr;

    logic [31:0] rdata_a, dbg_a, rdata_b, dbg_b;
    logic        mis_a, full_a, ovf_a, mis_b, full_b, ovf_b;
    logic [2:0]  cnt_a, cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_resp #(.ADDR_W(7), .WB_DEPTH(4), .WR_LAT(2)) u_a (
        .clk(clk), .reset(reset), .mem_w(mem_w), .DMType(DMType), .Addr_in(addr),
        .WData_in(wdata), .RData_out(rdata_a), .misalign(mis_a), .dbg_addr(dbg_addr),
        .dbg_data(dbg_a), .wb_count(cnt_a), .wb_full(full_a), .overflow(ovf_a)
    );

    dmem_resp #(.ADDR_W(7), .WB_DEPTH(4), .WR_LAT(8)) u_b (
        .clk(clk), .reset(reset), .mem_w(mem_w), .DMType(DMType), .Addr_in(addr),
        .WData_in(wdata), .RData_out(rdata_b), .misalign(mis_b), .dbg_addr(dbg_addr),
        .dbg_data(dbg_b), .wb_count(cnt_b), .wb_full(full_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] dm, input logic [31:0] a, input logic [31:0] d);
        mem_w  = 1'b1;
        DMType = dm;
        addr   = a;
        wdata  = d;
        tick();
        mem_w  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] dm, input logic [31:0] a,
                        input logic [31:0] exp);
        mem_w  = 1'b0;
        DMType = dm;
        addr   = a;
        #1;
        check(tag, rdata_a, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset = 1'b1; mem_w = 1'b0; DMType = DM_WORD; addr = '0; wdata = '0; dbg_addr = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_count_a", cnt_a, 0);
        check("rst_full_a", full_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_count_b", cnt_b, 0);

        // Known array background for words touched later.
        store(DM_WORD, 32'h10, 32'h0);
        store(DM_WORD, 32'h30, 32'h11111111);
        store(DM_WORD, 32'h34, 32'h11111111);
        repeat (30) tick();

        // 1: word store visible from buffer, array commit exactly two edges later
        store(DM_WORD, 32'h10, 32'h12345678);
        load("t1_lw_buf", DM_WORD, 32'h10, 32'h12345678);
        check("t1_count", cnt_a, 1);
        dbg_addr = 7'd4;
        tick();
        check("t1_dbg_edge1", dbg_a, 32'h0);
        tick();
        check("t1_dbg_edge2", dbg_a, 32'h12345678);
        check("t1_count_drained", cnt_a, 0);

        // 2: byte store merged over committed word
        store(DM_BYTE, 32'h11, 32'h00000080);
        load("t2_lb", DM_BYTE, 32'h11, 32'hFFFFFF80);
        load("t2_lbu", DM_BYTE_U, 32'h11, 32'h00000080);
        load("t2_lw", DM_WORD, 32'h10, 32'h12348078);
        load("t2_lh", DM_HALF, 32'h10, 32'hFFFF8078);
        load("t2_lhu_hi", DM_HALF_U, 32'h12, 32'h00001234);
        repeat (4) tick();
        check("t2_dbg", dbg_a, 32'h12348078);

        // 3: back-to-back overlapping stores, youngest wins; push+pop edge keeps count
        store(DM_WORD, 32'h20, 32'h0);
        store(DM_HALF, 32'h20, 32'h0000AAAA);
        load("t3_lw_two", DM_WORD, 32'h20, 32'h0000AAAA);
        store(DM_BYTE, 32'h21, 32'h000000BB);
        load("t3_lw_pending", DM_WORD, 32'h20, 32'h0000BBAA);
        check("t3_count_pushpop", cnt_a, 2);
        repeat (10) tick();
        load("t3_lw_drained", DM_WORD, 32'h20, 32'h0000BBAA);
        dbg_addr = 7'd8;
        #1;
        check("t3_dbg", dbg_a, 32'h0000BBAA);
        check("t3_count_zero", cnt_a, 0);

        // 5: misaligned accesses
        load("t5_lw_mis_data", DM_WORD, 32'h13, 32'h0);
        check("t5_lw_mis_flag", mis_a, 1);
        load("t5_lh_mis_data", DM_HALF, 32'h11, 32'h0);
        check("t5_lh_mis_flag", mis_a, 1);
        load("t5_lbu_b3", DM_BYTE_U, 32'h13, 32'h00000012);
        check("t5_lb_flag", mis_a, 0);
        store(DM_HALF, 32'h21, 32'h0000FFFF);
        check("t5_sh_mis_count", cnt_a, 0);
        check("t5_sh_mis_ovf", ovf_a, 0);
        repeat (4) tick();
        check("t5_sh_mis_dbg", dbg_a, 32'h0000BBAA);

        // 4: WR_LAT=8 instance fills, 5th store dropped
        reset = 1'b1; tick(); reset = 1'b0;
        store(DM_WORD, 32'h50, 32'hCAFEF00D);
        repeat (20) tick();
        dbg_addr = 7'h14;
        #1;
        check("t4_prewrite", dbg_b, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            store(DM_WORD, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i));
            if (i == 3) begin
                check("t4_full_after4", full_b, 1);
                check("t4_count_after4", cnt_b, 4);
                check("t4_ovf_before5", ovf_b, 0);
            end
        end
        check("t4_ovf", ovf_b, 1);
        check("t4_count_after5", cnt_b, 4);
        DMType = DM_WORD; addr = 32'h50;
        #1;
        check("t4_dropped_read", rdata_b, 32'hCAFEF00D);
        addr = 32'h4C;
        #1;
        check("t4_4th_read", rdata_b, 32'hA0000003);
        repeat (40) tick();
        check("t4_dropped_never_written", dbg_b, 32'hCAFEF00D);
        check("t4_ovf_sticky", ovf_b, 1);

        // 6: reset while two stores are pending
        store(DM_WORD, 32'h30, 32'hDEAD0001);
        store(DM_WORD, 32'h34, 32'hDEAD0002);
        check("t6_count_pre", cnt_a, 2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_count_a", cnt_a, 0);
        check("t6_count_b", cnt_b, 0);
        check("t6_ovf_b", ovf_b, 0);
        check("t6_full_b", full_b, 0);
        check("t6_fsm_idle", u_a.state_q, DRAIN_IDLE);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            dbg_addr = 7'd12;
            #1;
            if (dbg_a == 32'hDEAD0001) seen = 1'b1;
            dbg_addr = 7'd13;
            #1;
            if (dbg_a == 32'hDEAD0002) seen = 1'b1;
            tick();
        end
        check("t6_never_committed", seen, 0);
        check("t6_old_word", dbg_a, 32'h11111111);
        store(DM_WORD, 32'h34, 32'h55AA55AA);
        tick();
        check("t6_post_edge1", dbg_a, 32'h11111111);
        tick();
        check("t6_post_edge2", dbg_a, 32'h55AA55AA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
